// File: rtl/spi_input_conditioner_if.sv
// Bundle of raw SPI pins and their conditioned, clock-domain-safe counterparts.
// The bench or pad ring drives the pins through master; the conditioner uses slave.
interface spi_input_conditioner_if;
  logic sclk_raw;
  logic cs_raw;
  logic mosi_raw;
  logic sclk_cond;
  logic cs_cond;
  logic mosi_cond;
  logic sclk_pos;
  logic sclk_neg;
  logic cs_fall;
  logic cs_rise;

  modport master (
    output sclk_raw, cs_raw, mosi_raw,
    input  sclk_cond, cs_cond, mosi_cond, sclk_pos, sclk_neg, cs_fall, cs_rise
  );

  modport slave (
    input  sclk_raw, cs_raw, mosi_raw,
    output sclk_cond, cs_cond, mosi_cond, sclk_pos, sclk_neg, cs_fall, cs_rise
  );
endinterface

// File: rtl/spi_input_conditioner.sv
// SPI pin front end: 2-flop synchronizer, stability-counter debounce and
// registered edge pulses for sclk, cs and mosi, feeding the SPI slave FSM.
module spi_input_conditioner #(
  parameter int COUNTER_WIDTH = 3,
  parameter int WAIT_TIME     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_input_conditioner_if.slave spi
);

  localparam int NPINS = 3;
  localparam int SCLK  = 0;
  localparam int CS    = 1;
  localparam int MOSI  = 2;

  // Idle levels: sclk low, cs high (deselected), mosi low. Loading these into the
  // sync flops on reset keeps the first post-reset cycles free of spurious edges.
  localparam logic [NPINS-1:0]         IDLE_LEVEL = 3'b010;
  localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT   = COUNTER_WIDTH'(WAIT_TIME);

  logic [NPINS-1:0]         raw;
  logic [NPINS-1:0]         s1_q, s1_d;
  logic [NPINS-1:0]         s2_q, s2_d;
  logic [NPINS-1:0]         cond_q, cond_d;
  logic [NPINS-1:0]         flip;
  logic [COUNTER_WIDTH-1:0] cnt_q [NPINS];
  logic [COUNTER_WIDTH-1:0] cnt_d [NPINS];
  logic                     sclk_pos_q, sclk_pos_d;
  logic                     sclk_neg_q, sclk_neg_d;
  logic                     cs_fall_q, cs_fall_d;
  logic                     cs_rise_q, cs_rise_d;

  assign raw = {spi.mosi_raw, spi.cs_raw, spi.sclk_raw};

  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    cond_d = cond_q;
    for (int i = 0; i < NPINS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != cond_q[i]) begin
        if (cnt_q[i] == WAIT_CNT) begin
          cond_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    flip = cond_d ^ cond_q;

    // sclk pulses are gated by cs as it stood before this edge, so a frame's
    // first sclk movement coinciding with cs falling is deliberately dropped.
    sclk_pos_d = flip[SCLK] &  cond_d[SCLK] & ~cond_q[CS];
    sclk_neg_d = flip[SCLK] & ~cond_d[SCLK] & ~cond_q[CS];
    cs_fall_d  = flip[CS]   & ~cond_d[CS];
    cs_rise_d  = flip[CS]   &  cond_d[CS];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= IDLE_LEVEL;
      s2_q       <= IDLE_LEVEL;
      cond_q     <= IDLE_LEVEL;
      for (int i = 0; i < NPINS; i++) begin
        cnt_q[i] <= '0;
      end
      sclk_pos_q <= 1'b0;
      sclk_neg_q <= 1'b0;
      cs_fall_q  <= 1'b0;
      cs_rise_q  <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cond_q     <= cond_d;
      for (int i = 0; i < NPINS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sclk_pos_q <= sclk_pos_d;
      sclk_neg_q <= sclk_neg_d;
      cs_fall_q  <= cs_fall_d;
      cs_rise_q  <= cs_rise_d;
    end
  end

  assign spi.sclk_cond = cond_q[SCLK];
  assign spi.cs_cond   = cond_q[CS];
  assign spi.mosi_cond = cond_q[MOSI];
  assign spi.sclk_pos  = sclk_pos_q;
  assign spi.sclk_neg  = sclk_neg_q;
  assign spi.cs_fall   = cs_fall_q;
  assign spi.cs_rise   = cs_rise_q;

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Directed bench for spi_input_conditioner: default WAIT_TIME=3 instance plus a
// WAIT_TIME=0 instance sharing the same raw pins and reset.
module tb_spi_input_conditioner;

  logic clk;
  logic reset;
  logic sclk_raw;
  logic cs_raw;
  logic mosi_raw;

  int vectorCount;
  int missCount;
  int posCount;
  int negCount;

  spi_input_conditioner_if bus3 ();
  spi_input_conditioner_if bus0 ();

  assign bus3.sclk_raw = sclk_raw;
  assign bus3.cs_raw   = cs_raw;
  assign bus3.mosi_raw = mosi_raw;
  assign bus0.sclk_raw = sclk_raw;
  assign bus0.cs_raw   = cs_raw;
  assign bus0.mosi_raw = mosi_raw;

  spi_input_conditioner #(.COUNTER_WIDTH(3), .WAIT_TIME(3)) dut (
    .clk   (clk),
    .reset (reset),
    .spi   (bus3.slave)
  );

  spi_input_conditioner #(.COUNTER_WIDTH(3), .WAIT_TIME(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .spi   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every call counts one vector; a miscompare prints a single FAIL line.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic c, input logic m);
    sclk_raw = s;
    cs_raw   = c;
    mosi_raw = m;
  endtask

  // Advance n rising edges; afterwards we sit 1 time unit past the last edge.
  task automatic stepClock(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    stepClock(2);
    reset = 1'b0;
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    doReset();

    checkOutput("rst_sclk_cond", bus3.sclk_cond, 0);
    checkOutput("rst_cs_cond",   bus3.cs_cond,   1);
    checkOutput("rst_mosi_cond", bus3.mosi_cond, 0);
    checkOutput("rst_pulses", {bus3.sclk_pos, bus3.sclk_neg, bus3.cs_fall, bus3.cs_rise}, 0);

    // Clean select: cs falls at the sixth edge after the pin change
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClock(5);
    checkOutput("cs_edge5_cond", bus3.cs_cond, 1);
    checkOutput("cs_edge5_fall", bus3.cs_fall, 0);
    stepClock(1);
    checkOutput("cs_edge6_cond", bus3.cs_cond, 0);
    checkOutput("cs_edge6_fall", bus3.cs_fall, 1);
    checkOutput("cs_edge6_sclk", {bus3.sclk_pos, bus3.sclk_neg}, 0);
    stepClock(1);
    checkOutput("cs_edge7_fall", bus3.cs_fall, 0);

    // 3-cycle mosi glitch is rejected
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClock(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      stepClock(1);
      checkOutput("mosi_glitch", bus3.mosi_cond, 0);
    end

    // 4-cycle mosi high is accepted at edge 6
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClock(4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClock(1);
    checkOutput("mosi4_edge5", bus3.mosi_cond, 0);
    stepClock(1);
    checkOutput("mosi4_edge6", bus3.mosi_cond, 1);
    stepClock(4);
    checkOutput("mosi4_back_low", bus3.mosi_cond, 0);
    stepClock(6);

    // Selected clocking: 8 raw sclk edges, half-period 10 clocks
    posCount = 0;
    negCount = 0;
    for (int h = 0; h < 8; h++) begin
      applyStimulus(~sclk_raw, 1'b0, 1'b0);
      for (int t = 1; t <= 10; t++) begin
        stepClock(1);
        posCount += int'(bus3.sclk_pos);
        negCount += int'(bus3.sclk_neg);
        if (t == 5) begin
          checkOutput("sel_pre_pulse", {bus3.sclk_pos, bus3.sclk_neg}, 0);
        end
        if (t == 6) begin
          checkOutput("sel_pulse", {bus3.sclk_pos, bus3.sclk_neg}, sclk_raw ? 32'd2 : 32'd1);
          checkOutput("sel_cond", bus3.sclk_cond, sclk_raw);
        end
      end
    end
    checkOutput("sel_pos_count", posCount, 4);
    checkOutput("sel_neg_count", negCount, 4);

    // Deselect, then clock: cond tracks but no pulses
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepClock(10);
    checkOutput("desel_cs_cond", bus3.cs_cond, 1);
    posCount = 0;
    negCount = 0;
    for (int h = 0; h < 4; h++) begin
      applyStimulus(~sclk_raw, 1'b1, 1'b0);
      for (int t = 1; t <= 10; t++) begin
        stepClock(1);
        posCount += int'(bus3.sclk_pos);
        negCount += int'(bus3.sclk_neg);
        if (t == 6) begin
          checkOutput("desel_cond", bus3.sclk_cond, sclk_raw);
        end
      end
    end
    checkOutput("desel_pulses", posCount + negCount, 0);

    // cs falling together with sclk rising: sclk pulse suppressed
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepClock(6);
    checkOutput("simf_cs_cond",   bus3.cs_cond,   0);
    checkOutput("simf_sclk_cond", bus3.sclk_cond, 1);
    checkOutput("simf_cs_fall",   bus3.cs_fall,   1);
    checkOutput("simf_sclk_pos",  bus3.sclk_pos,  0);
    stepClock(1);
    checkOutput("simf_after", {bus3.sclk_pos, bus3.sclk_neg, bus3.cs_fall}, 0);
    stepClock(3);

    // cs rising together with sclk falling: sclk pulse fires
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepClock(6);
    checkOutput("simr_cs_rise",  bus3.cs_rise,  1);
    checkOutput("simr_sclk_neg", bus3.sclk_neg, 1);
    stepClock(4);

    // Reset two cycles into an sclk debounce
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepClock(2);
    reset = 1'b1;
    stepClock(1);
    checkOutput("mid_rst_sclk_cond", bus3.sclk_cond, 0);
    checkOutput("mid_rst_pulses", {bus3.sclk_pos, bus3.sclk_neg, bus3.cs_fall, bus3.cs_rise}, 0);
    reset = 1'b0;
    stepClock(5);
    checkOutput("mid_rst_edge5", bus3.sclk_cond, 0);
    stepClock(1);
    checkOutput("mid_rst_edge6", bus3.sclk_cond, 1);
    checkOutput("mid_rst_nopos", bus3.sclk_pos,  0);

    // WAIT_TIME = 0 instance
    applyStimulus(1'b0, 1'b1, 1'b0);
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClock(2);
    checkOutput("w0_edge2_cs", bus0.cs_cond, 1);
    stepClock(1);
    checkOutput("w0_edge3_cs",   bus0.cs_cond, 0);
    checkOutput("w0_edge3_fall", bus0.cs_fall, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepClock(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepClock(2);
    checkOutput("w0_glitch_hi", bus0.mosi_cond, 1);
    stepClock(1);
    checkOutput("w0_glitch_lo", bus0.mosi_cond, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
